pc_sequencer: RTL and testbench

//   Program-counter generator driving the fetch stage's pc input. Replaces the

---
 rtl/pc_sequencer.sv | 94 +++++++++
 tb/tb_pc_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter front end: issues word-addressed PCs to fetch under valid/ready,
// with pause, redirect and halt. Define PC_ISSUE_COUNT_EN to add the issue_count output.
//
// state | meaning
// IDLE  | paused, pc held, no request to fetch
// RUN   | pc_valid asserted, pc advances on each transfer
// HALT  | stopped until reset, all other inputs ignored
module pc_sequencer #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [WIDTH-1:0]  INCREMENT = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0]  PC_LIMIT  = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             halted
`ifdef PC_ISSUE_COUNT_EN
  ,
  output logic [31:0]      issue_count
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic             transfer;
  logic             limit_hit;

  // pc_valid is only ever high in RUN, so a transfer can only happen there
  assign transfer  = pc_valid & fetch_ready;
  assign limit_hit = transfer & (pc == PC_LIMIT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (halt_req)      state_nxt = ST_HALT;
        else if (enable)   state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req)       state_nxt = ST_HALT;
        else if (limit_hit) state_nxt = ST_HALT;
        else if (!enable)   state_nxt = ST_IDLE;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Redirect wins over increment; the outgoing pc is dropped even if fetch took it
  always_comb begin
    pc_nxt = pc;
    if (state != ST_HALT) begin
      if (redirect_valid)  pc_nxt = redirect_target;
      else if (transfer)   pc_nxt = pc + INCREMENT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pc_valid <= (state_nxt == ST_RUN);
      halted   <= (state_nxt == ST_HALT);
    end
  end

`ifdef PC_ISSUE_COUNT_EN
  // Counts accepted issues for the lifetime since reset; redirect/halt leave it alone
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         issue_count <= 32'd0;
    else if (transfer) issue_count <= issue_count + 32'd1;
  end
`else
  // default build carries no issue counter
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: default, low-limit and wrapping instances.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;

  logic [31:0] pc,      lim_pc,      wrap_pc;
  logic        pc_valid, lim_valid,  wrap_valid;
  logic        halted,  lim_halted,  wrap_halted;
`ifdef PC_ISSUE_COUNT_EN
  logic [31:0] issue_count, lim_count, wrap_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pc_sequencer u_dut (
    .clock(clock), .reset(reset), .enable(enable), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .pc(pc), .pc_valid(pc_valid), .halted(halted)
`ifdef PC_ISSUE_COUNT_EN
    , .issue_count(issue_count)
`endif
  );

  pc_sequencer #(.PC_LIMIT(32'd3)) u_lim (
    .clock(clock), .reset(reset), .enable(enable), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .pc(lim_pc), .pc_valid(lim_valid), .halted(lim_halted)
`ifdef PC_ISSUE_COUNT_EN
    , .issue_count(lim_count)
`endif
  );

  pc_sequencer #(.INCREMENT(32'd4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock(clock), .reset(reset), .enable(enable), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .pc(wrap_pc), .pc_valid(wrap_valid), .halted(wrap_halted)
`ifdef PC_ISSUE_COUNT_EN
    , .issue_count(wrap_count)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; halt_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h valid=%b halted=%b, need pc=0 valid=0 halted=0", pc, pc_valid, halted);
    end
    n_checks++;
    if (wrap_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL reset_pc_param: pc=%h, need fffffffc", wrap_pc);
    end
`ifdef PC_ISSUE_COUNT_EN
    n_checks++;
    if (issue_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count: issue_count=%0d, need 0", issue_count);
    end
`endif
  endtask

  // Five edges with enable/ready high: first edge only raises pc_valid
  task automatic test_run();
    enable = 1'b1; fetch_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (pc !== 32'(i) || pc_valid !== 1'b1 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL run_seq[%0d]: pc=%h valid=%b halted=%b, need pc=%h valid=1 halted=0", i, pc, pc_valid, halted, 32'(i));
      end
    end
  endtask

  task automatic test_stall();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (pc !== 32'd4 || pc_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%h valid=%b, need pc=4 valid=1", i, pc, pc_valid);
      end
    end
    fetch_ready = 1'b1;
    step();
    n_checks++;
    if (pc !== 32'd5) begin
      n_fail++;
      $display("FAIL stall_resume: pc=%h, need 5", pc);
    end
    step();
    step();
  endtask

  task automatic test_redirect();
    n_checks++;
    if (pc !== 32'd7) begin
      n_fail++;
      $display("FAIL redirect_pre: pc=%h, need 7", pc);
    end
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (pc !== 32'h40 || pc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_target: pc=%h valid=%b, need pc=40 valid=1", pc, pc_valid);
    end
    step();
    n_checks++;
    if (pc !== 32'h41) begin
      n_fail++;
      $display("FAIL redirect_follow: pc=%h, need 41", pc);
    end
`ifdef PC_ISSUE_COUNT_EN
    n_checks++;
    if (issue_count !== 32'd9) begin
      n_fail++;
      $display("FAIL count_transfers: issue_count=%0d, need 9", issue_count);
    end
`endif
  endtask

  task automatic test_halt_redirect();
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
    step();
    halt_req = 1'b0; redirect_target = 32'h10;
    n_checks++;
    if (pc !== 32'h80 || pc_valid !== 1'b0 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_redirect: pc=%h valid=%b halted=%b, need pc=80 valid=0 halted=1", pc, pc_valid, halted);
    end
    enable = 1'b1; fetch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (pc !== 32'h80 || pc_valid !== 1'b0 || halted !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_sticky[%0d]: pc=%h valid=%b halted=%b, need pc=80 valid=0 halted=1", i, pc, pc_valid, halted);
      end
    end
    redirect_valid = 1'b0;
`ifdef PC_ISSUE_COUNT_EN
    n_checks++;
    if (issue_count !== 32'd10) begin
      n_fail++;
      $display("FAIL count_halt: issue_count=%0d, need 10", issue_count);
    end
`endif
  endtask

  task automatic test_limit();
    do_reset();
    enable = 1'b1; fetch_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (wrap_pc !== 32'h0 || wrap_valid !== 1'b1 || wrap_halted !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_pc: pc=%h valid=%b halted=%b, need pc=0 valid=1 halted=0", wrap_pc, wrap_valid, wrap_halted);
    end
    step();
    step();
    n_checks++;
    if (lim_pc !== 32'd3 || lim_valid !== 1'b1 || lim_halted !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_last: pc=%h valid=%b halted=%b, need pc=3 valid=1 halted=0", lim_pc, lim_valid, lim_halted);
    end
    step();
    n_checks++;
    if (lim_pc !== 32'd4 || lim_valid !== 1'b0 || lim_halted !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_halt: pc=%h valid=%b halted=%b, need pc=4 valid=0 halted=1", lim_pc, lim_valid, lim_halted);
    end
    n_checks++;
    if (pc !== 32'd4 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_default: pc=%h halted=%b, need pc=4 halted=0", pc, halted);
    end
  endtask

  task automatic test_pause();
    enable = 1'b0; fetch_ready = 1'b0;
    step();
    n_checks++;
    if (pc !== 32'd4 || pc_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_drop: pc=%h valid=%b halted=%b, need pc=4 valid=0 halted=0", pc, pc_valid, halted);
    end
    enable = 1'b1;
    step();
    n_checks++;
    if (pc !== 32'd4 || pc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_resume: pc=%h valid=%b, need pc=4 valid=1", pc, pc_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1; fetch_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (pc !== 32'd9 || pc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: pc=%h valid=%b, need pc=9 valid=1", pc, pc_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h valid=%b halted=%b, need pc=0 valid=0 halted=0", pc, pc_valid, halted);
    end
`ifdef PC_ISSUE_COUNT_EN
    n_checks++;
    if (issue_count !== 32'd0) begin
      n_fail++;
      $display("FAIL async_count: issue_count=%0d, need 0", issue_count);
    end
`endif
    step();
    reset = 1'b0;
    enable = 1'b0; fetch_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; halt_req = 1'b0;
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_halt_redirect();
    test_limit();
    test_pause();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
